// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC sin/cos controller and step chain.
//   W_DEFAULT       fixed-point width (Q2.10 signed)
//   STAGES_DEFAULT  number of cordic_step stages
//   K_INV           gain-compensated start magnitude (0.6073 * 1024)
//   HALF_PI         clamp limit for request angles (pi/2 in Q2.10)
//   ATAN_TABLE      per-stage rotation angle atan(2^-i) in Q2.10, fed to each stage's atan
//   ctrl_state_t    controller FSM state
package cordic_pkg;

    localparam int unsigned W_DEFAULT      = 12;
    localparam int unsigned STAGES_DEFAULT = 12;
    localparam int          K_INV          = 622;
    localparam int          HALF_PI        = 1608;

    localparam int ATAN_TABLE [0:STAGES_DEFAULT-1] = '{
        804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStall
    } ctrl_state_t;

endpackage

// File: rtl/cordic_tag_pipe.sv
// cordic_tag_pipe: enable-gated valid/tag/sat shift register that tracks which CORDIC
// pipeline slots hold live samples. Advances only while ce is high.
// Ports:
//   clock, reset_n   clock, asynchronous active-low reset (clears every slot)
//   ce               shift enable, shared with the step chain
//   in_valid         slot-0 valid (an accepted request; 0 loads a bubble)
//   in_tag, in_sat   slot-0 tag and clamp flag
//   last_valid/tag/sat  contents of the final slot
//   upper_any        OR of every slot except the last (live samples still behind the head)
module cordic_tag_pipe #(
    parameter int unsigned STAGES = 12,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_sat,
    output logic             last_valid,
    output logic [TAG_W-1:0] last_tag,
    output logic             last_sat,
    output logic             upper_any
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] sat_q;
    logic [TAG_W-1:0]  tag_q [STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            sat_q   <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                tag_q[i] <= '0;
            end
        end else if (ce) begin
            valid_q  <= {valid_q[STAGES-2:0], in_valid};
            sat_q    <= {sat_q[STAGES-2:0], in_sat};
            tag_q[0] <= in_tag;
            for (int i = 1; i < int'(STAGES); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign last_valid = valid_q[STAGES-1];
    assign last_sat   = sat_q[STAGES-1];
    assign last_tag   = tag_q[STAGES-1];
    assign upper_any  = |valid_q[STAGES-2:0];

endmodule

// File: rtl/cordic_ctrl.sv
// cordic_ctrl: sequencing controller for the pipelined CORDIC sin/cos step chain.
// Accepts angle requests (valid/ready), drives the chain head with the gain-compensated
// start vector and the clamped target angle, tracks live slots with their tags, and
// freezes the whole chain via pipe_ce while a result is back-pressured.
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_angle/in_tag   request handshake (angle Q2.10, user tag)
//   pipe_ce                         clock enable to every step stage
//   pipe_sin0/cos0/angle0/t_angle0  stage-0 inputs
//   pipe_sin_last/cos_last          final stage outputs
//   out_valid/out_ready/out_sin/out_cos/out_tag/out_sat   result handshake
//   busy                            at least one live sample in flight
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned W      = W_DEFAULT,
    parameter int unsigned STAGES = STAGES_DEFAULT,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_angle,
    input  logic [TAG_W-1:0] in_tag,
    output logic             pipe_ce,
    output logic [W-1:0]     pipe_sin0,
    output logic [W-1:0]     pipe_cos0,
    output logic [W-1:0]     pipe_angle0,
    output logic [W-1:0]     pipe_t_angle0,
    input  logic [W-1:0]     pipe_sin_last,
    input  logic [W-1:0]     pipe_cos_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sin,
    output logic [W-1:0]     out_cos,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat,
    output logic             busy
);

    localparam logic signed [W-1:0] ClampHi = W'(HALF_PI);
    localparam logic signed [W-1:0] ClampLo = -ClampHi;

    logic                stall;
    logic                accept;
    logic                upper_any;
    logic                next_live;
    logic                sat;
    logic signed [W-1:0] angle_s;
    logic signed [W-1:0] t_angle;
    ctrl_state_t         state_q;
    ctrl_state_t         state_d;

    // Handshake and chain enable; out_ready -> in_ready is the only comb path through.
    assign stall    = out_valid & ~out_ready;
    assign pipe_ce  = ~stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Clamp the request to +/- pi/2 and flag it when clamping happened.
    assign angle_s = $signed(in_angle);

    always_comb begin
        t_angle = angle_s;
        sat     = 1'b0;
        if (angle_s > ClampHi) begin
            t_angle = ClampHi;
            sat     = 1'b1;
        end else if (angle_s < ClampLo) begin
            t_angle = ClampLo;
            sat     = 1'b1;
        end
    end

    assign pipe_cos0     = W'(K_INV);
    assign pipe_sin0     = '0;
    assign pipe_angle0   = '0;
    assign pipe_t_angle0 = t_angle;

    cordic_tag_pipe #(
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) u_tag_pipe (
        .clock      (clock),
        .reset_n    (reset_n),
        .ce         (pipe_ce),
        .in_valid   (accept),
        .in_tag     (in_tag),
        .in_sat     (accept & sat),
        .last_valid (out_valid),
        .last_tag   (out_tag),
        .last_sat   (out_sat),
        .upper_any  (upper_any)
    );

    assign out_sin = pipe_sin_last;
    assign out_cos = pipe_cos_last;

    // Any slot live after the next enabled edge: a new accept or a sample behind the head.
    assign next_live = accept | upper_any;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StRun;
            end
            StRun: begin
                if (stall)           state_d = StStall;
                else if (!next_live) state_d = StIdle;
            end
            StStall: begin
                // Releasing the last held result with nothing behind it empties the chain.
                if (out_ready) state_d = next_live ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Non-idle exactly when some slot is live.
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_ctrl.sv
// tb_cordic_ctrl: self-checking bench for cordic_ctrl. A behavioural step chain stands in
// for the cordic_step instances; a queue model predicts every result and its timing.
module tb_cordic_ctrl;
    import cordic_pkg::*;

    localparam int W      = 12;
    localparam int STAGES = 12;
    localparam int TAG_W  = 4;
    localparam int FB     = 10;  // extra fraction bits inside the stand-in chain

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_angle = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             pipe_ce;
    logic [W-1:0]     pipe_sin0, pipe_cos0, pipe_angle0, pipe_t_angle0;
    logic [W-1:0]     pipe_sin_last, pipe_cos_last;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_sin, out_cos;
    logic [TAG_W-1:0] out_tag;
    logic             out_sat;
    logic             busy;

    int checks = 0;
    int failures = 0;

    cordic_ctrl #(
        .W      (W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_angle      (in_angle),
        .in_tag        (in_tag),
        .pipe_ce       (pipe_ce),
        .pipe_sin0     (pipe_sin0),
        .pipe_cos0     (pipe_cos0),
        .pipe_angle0   (pipe_angle0),
        .pipe_t_angle0 (pipe_t_angle0),
        .pipe_sin_last (pipe_sin_last),
        .pipe_cos_last (pipe_cos_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sin       (out_sin),
        .out_cos       (out_cos),
        .out_tag       (out_tag),
        .out_sat       (out_sat),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int rnd(input int v);
        return (v + (1 <<< (FB - 1))) >>> FB;
    endfunction

    function automatic int clampv(input int a);
        if (a > HALF_PI) return HALF_PI;
        if (a < -HALF_PI) return -HALF_PI;
        return a;
    endfunction

    // One CORDIC rotation step, rotation mode.
    function automatic void cstep(input int i, input int xi, input int yi, input int zi,
                                  input int ti, output int xo, output int yo, output int zo);
        int d;
        d  = (zi < ti) ? 1 : -1;
        xo = xi - d * (yi >>> i);
        yo = yi + d * (xi >>> i);
        zo = zi + d * (ATAN_TABLE[i] <<< FB);
    endfunction

    function automatic void cordic_ref(input int ang, output int s, output int c);
        int x, y, z, t, nx, ny, nz;
        x = K_INV <<< FB;
        y = 0;
        z = 0;
        t = ang <<< FB;
        for (int i = 0; i < STAGES; i++) begin
            cstep(i, x, y, z, t, nx, ny, nz);
            x = nx;
            y = ny;
            z = nz;
        end
        s = rnd(y);
        c = rnd(x);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, exp, tol);
        end
    endtask

    // ---------------- stand-in step chain (not reset, like the real datapath) ----------------
    int cx [STAGES];
    int cy [STAGES];
    int cz [STAGES];
    int ct [STAGES];

    always @(posedge clock) begin : chain
        int xo, yo, zo;
        if (pipe_ce) begin
            cstep(0, sx(pipe_cos0) <<< FB, sx(pipe_sin0) <<< FB, sx(pipe_angle0) <<< FB,
                  sx(pipe_t_angle0) <<< FB, xo, yo, zo);
            cx[0] <= xo;
            cy[0] <= yo;
            cz[0] <= zo;
            ct[0] <= sx(pipe_t_angle0) <<< FB;
            for (int i = 1; i < STAGES; i++) begin
                cstep(i, cx[i-1], cy[i-1], cz[i-1], ct[i-1], xo, yo, zo);
                cx[i] <= xo;
                cy[i] <= yo;
                cz[i] <= zo;
                ct[i] <= ct[i-1];
            end
        end
    end

    assign pipe_sin_last = W'(rnd(cy[STAGES-1]));
    assign pipe_cos_last = W'(rnd(cx[STAGES-1]));

    // ---------------- reference model ----------------
    // Each accepted request waits out STAGES enabled edges, counting its accept edge.
    typedef struct {
        int rem;
        int tag;
        int sat;
        int s;
        int c;
    } item_t;

    item_t q[$];

    function automatic bit model_ov();
        return (q.size() > 0) && (q[0].rem == 0);
    endfunction

    initial begin : model
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                q.delete();
            end else begin
                bit    ov;
                bit    ce;
                item_t it;
                int    a;
                ov = model_ov();
                ce = !(ov && !out_ready);
                if (ce) begin
                    if (ov) void'(q.pop_front());
                    foreach (q[k]) q[k].rem--;
                    if (in_valid) begin
                        a      = sx(in_angle);
                        it.rem = STAGES - 1;
                        it.tag = int'(in_tag);
                        it.sat = (a != clampv(a)) ? 1 : 0;
                        cordic_ref(clampv(a), it.s, it.c);
                        q.push_back(it);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clock);
            if (reset_n) begin
                bit ov;
                ov = model_ov();
                check("in_ready", int'(in_ready), int'(!(ov && !out_ready)));
                check("pipe_ce", int'(pipe_ce), int'(!(ov && !out_ready)));
                check("out_valid", int'(out_valid), int'(ov));
                check("busy", int'(busy), (q.size() > 0) ? 1 : 0);
                check("t_angle0", sx(pipe_t_angle0), clampv(sx(in_angle)));
                check("cos0", sx(pipe_cos0), 622);
                check("sin0", sx(pipe_sin0), 0);
                check("angle0", sx(pipe_angle0), 0);
                if (ov && out_valid) begin
                    check("out_tag", int'(out_tag), q[0].tag);
                    check("out_sat", int'(out_sat), q[0].sat);
                    check("out_sin", sx(out_sin), q[0].s);
                    check("out_cos", sx(out_cos), q[0].c);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int ang, input int tag, input bit rdy);
        @(posedge clock);
        #2;
        in_valid  = v;
        in_angle  = W'(ang);
        in_tag    = TAG_W'(tag);
        out_ready = rdy;
    endtask

    // Counts falling edges until out_valid; a timeout counts as a failed comparison.
    task automatic wait_out(input string name, output int k);
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (out_valid) begin
                k = n;
                break;
            end
        end
        if (k == 0) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        int held_tag;
        int held_sin;
        int stale;

        // Reset values.
        @(posedge clock);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_pipe_ce", int'(pipe_ce), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_out_tag", int'(out_tag), 0);

        // Angle 0, tag 3, presented with reset release: accepted on the first edge.
        @(posedge clock);
        #2;
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_angle  = '0;
        in_tag    = 4'd3;
        out_ready = 1'b1;
        drive(0, 0, 0, 1);
        wait_out("zero", k);
        check("zero_latency", k, 12);
        check_near("zero_sin", sx(out_sin), 0, 4);
        check_near("zero_cos", sx(out_cos), 1024, 4);
        check("zero_tag", int'(out_tag), 3);
        check("zero_sat", int'(out_sat), 0);

        // pi/4.
        drive(1, 804, 4, 1);
        drive(0, 0, 0, 1);
        wait_out("pi4", k);
        check("pi4_latency", k, 12);
        check_near("pi4_sin", sx(out_sin), 724, 4);
        check_near("pi4_cos", sx(out_cos), 724, 4);

        // 12 back-to-back requests -> 12 consecutive in-order results.
        for (int j = 0; j < 12; j++) drive(1, int'($urandom_range(0, 3200)) - 1600, j, 1);
        drive(0, 0, 0, 1);
        wait_out("b2b", k);
        for (int j = 0; j < 12; j++) begin
            check("b2b_valid", int'(out_valid), 1);
            check("b2b_tag", int'(out_tag), j);
            if (j < 11) @(negedge clock);
        end

        // Back-pressure: result held frozen, then released in order.
        for (int j = 7; j <= 10; j++) drive(1, int'($urandom_range(0, 3200)) - 1600, j, 0);
        drive(0, 0, 0, 0);
        wait_out("stall", k);
        held_tag = int'(out_tag);
        held_sin = sx(out_sin);
        check("stall_first_tag", held_tag, 7);
        repeat (5) begin
            @(negedge clock);
            check("stall_ce", int'(pipe_ce), 0);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_hold_valid", int'(out_valid), 1);
            check("stall_hold_tag", int'(out_tag), held_tag);
            check("stall_hold_sin", sx(out_sin), held_sin);
        end
        drive(0, 0, 0, 1);
        @(negedge clock);
        check("release_tag7", int'(out_tag), 7);
        for (int j = 8; j <= 10; j++) begin
            @(negedge clock);
            check("release_valid", int'(out_valid), 1);
            check("release_tag", int'(out_tag), j);
        end

        // Saturation both ways.
        drive(1, 2000, 5, 1);
        #1;
        check("sat_t_angle_pos", sx(pipe_t_angle0), 1608);
        drive(1, -2000, 6, 1);
        #1;
        check("sat_t_angle_neg", sx(pipe_t_angle0), -1608);
        drive(0, 0, 0, 1);
        wait_out("sat", k);
        check("sat_pos_flag", int'(out_sat), 1);
        check("sat_pos_tag", int'(out_tag), 5);
        check_near("sat_pos_sin", sx(out_sin), 1024, 4);
        check_near("sat_pos_cos", sx(out_cos), 0, 4);
        @(negedge clock);
        check("sat_neg_flag", int'(out_sat), 1);
        check("sat_neg_tag", int'(out_tag), 6);
        check_near("sat_neg_sin", sx(out_sin), -1024, 4);

        // Reset with 6 samples in flight.
        for (int j = 0; j < 6; j++) drive(1, int'($urandom_range(0, 4095)), j, 1);
        @(posedge clock);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        check("no_stale_results", stale, 0);

        // Randomized traffic with random back-pressure, full angle range.
        repeat (500) begin
            drive(($urandom_range(0, 99) < 70), int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 65));
        end

        // Drain.
        repeat (20) drive(0, 0, 0, 1);
        @(negedge clock);
        check("drain_busy", int'(busy), 0);
        check("drain_model_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
